// File: rtl/aes_pkg.sv
// aes_pkg: shared definitions for the iterative AES encryption datapath.
//   fsm_e      - engine control states (IDLE/ROUND/DONE)
//   nr_of()    - round count for a key length (10/12/14)
//   rk_w_of()  - width of the flattened round-key bus, 128*(NR+1)
//   gf_xtime() - multiply-by-x in GF(2^8) modulo x^8+x^4+x^3+x+1
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } fsm_e;

  function automatic int nr_of(input int key_len);
    return (key_len == 128) ? 10 : (key_len == 192) ? 12 : 14;
  endfunction

  function automatic int rk_w_of(input int key_len);
    return 128 * (nr_of(key_len) + 1);
  endfunction

  function automatic logic [7:0] gf_xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_round.sv
// aes_round: one combinational AES encryption round.
//   state_i      [0:127] round input, FIPS-197 byte order (column-major)
//   rk_i         [0:127] round key for this round
//   final_i              last round: MixColumns is bypassed
//   next_state_o [0:127] SubBytes -> ShiftRows -> MixColumns -> AddRoundKey
module aes_round
  import aes_pkg::*;
(
  input  logic [0:127] state_i,
  input  logic [0:127] rk_i,
  input  logic         final_i,
  output logic [0:127] next_state_o
);

  logic [0:127] sub_w;
  logic [0:127] shift_w;
  logic [0:127] mix_w;

  sbox_128 u_sbox (
    .din_i  (state_i),
    .dout_o (sub_w)
  );

  genvar gi;

  // Byte index b sits at row b%4, column b/4; row r rotates left by r columns.
  for (gi = 0; gi < 16; gi++) begin : g_shift
    localparam int ROW = gi % 4;
    localparam int COL = gi / 4;
    localparam int SRC = ROW + 4 * ((COL + ROW) % 4);
    assign shift_w[8*gi +: 8] = sub_w[8*SRC +: 8];
  end

  // Each column is multiplied by the circulant {02,03,01,01}; 3*a = xtime(a)^a.
  for (gi = 0; gi < 4; gi++) begin : g_mix
    logic [7:0] a0, a1, a2, a3;
    assign a0 = shift_w[32*gi      +: 8];
    assign a1 = shift_w[32*gi + 8  +: 8];
    assign a2 = shift_w[32*gi + 16 +: 8];
    assign a3 = shift_w[32*gi + 24 +: 8];
    assign mix_w[32*gi      +: 8] = gf_xtime(a0) ^ gf_xtime(a1) ^ a1 ^ a2 ^ a3;
    assign mix_w[32*gi + 8  +: 8] = a0 ^ gf_xtime(a1) ^ gf_xtime(a2) ^ a2 ^ a3;
    assign mix_w[32*gi + 16 +: 8] = a0 ^ a1 ^ gf_xtime(a2) ^ gf_xtime(a3) ^ a3;
    assign mix_w[32*gi + 24 +: 8] = gf_xtime(a0) ^ a0 ^ a1 ^ a2 ^ gf_xtime(a3);
  end

  assign next_state_o = (final_i ? shift_w : mix_w) ^ rk_i;

endmodule

// File: rtl/sbox_128.sv
// sbox_128: applies the AES forward S-box to all 16 bytes of a block.
//   din_i  [0:127] input block, byte 0 in bits [0:7]
//   dout_o [0:127] substituted block, same byte order
// Purely combinational; the table is indexed by byte value, entry 0 first.
module sbox_128 (
  input  logic [0:127] din_i,
  output logic [0:127] dout_o
);

  localparam logic [0:2047] SBOX_TAB = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  genvar gi;
  for (gi = 0; gi < 16; gi++) begin : g_byte
    assign dout_o[8*gi +: 8] = SBOX_TAB[8*din_i[8*gi +: 8] +: 8];
  end

endmodule

// File: rtl/aes_round_engine.sv
// aes_round_engine: iterative AES encryptor, one round per clock.
//   clk, rst_n   clock, asynchronous active-low reset
//   in_valid/in_ready    plaintext + round keys handshake
//   plaintext  [0:127]   input block (FIPS-197 bit order)
//   round_keys [0:RK_W-1] round key i in bits [128*i +: 128]; not latched,
//                         must stay stable from accept until out_valid
//   out_valid/out_ready  ciphertext handshake
//   ciphertext [0:127]   result, held while out_valid is high
//   busy                 high while rounds are being computed
module aes_round_engine
  import aes_pkg::*;
#(
  parameter  int KEY_LEN = 128,
  localparam int NR      = nr_of(KEY_LEN),
  localparam int RK_W    = rk_w_of(KEY_LEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [0:127]    plaintext,
  input  logic [0:RK_W-1] round_keys,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [0:127]    ciphertext,
  output logic            busy
);

  if (KEY_LEN != 128 && KEY_LEN != 192 && KEY_LEN != 256) begin : g_bad_key_len
    $error("aes_round_engine: KEY_LEN must be 128, 192 or 256");
  end

  localparam logic [3:0] NR_L = 4'(NR);

  fsm_e         fsm_q, fsm_d;
  logic [0:127] state_q, state_d;
  logic [3:0]   rcnt_q, rcnt_d;
  logic [0:127] round_out;
  logic         accept;

  // Fixed 16-entry view of the key bus so the counter indexes it without
  // any out-of-range select; entries past NR are never addressed.
  logic [0:127] rk_arr [16];

  genvar gi;
  for (gi = 0; gi < 16; gi++) begin : g_rk
    if (gi <= NR) begin : g_used
      assign rk_arr[gi] = round_keys[128*gi +: 128];
    end else begin : g_unused
      assign rk_arr[gi] = '0;
    end
  end

  aes_round u_round (
    .state_i      (state_q),
    .rk_i         (rk_arr[rcnt_q]),
    .final_i      (rcnt_q == NR_L),
    .next_state_o (round_out)
  );

  // DONE accepts a new block on the same edge its result is consumed.
  assign in_ready = (fsm_q == IDLE) || ((fsm_q == DONE) && out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    rcnt_d  = rcnt_q;
    case (fsm_q)
      IDLE: begin
        if (accept) begin
          state_d = plaintext ^ rk_arr[0];
          rcnt_d  = 4'd1;
          fsm_d   = ROUND;
        end
      end
      ROUND: begin
        state_d = round_out;
        if (rcnt_q == NR_L) begin
          rcnt_d = 4'd0;
          fsm_d  = DONE;
        end else begin
          rcnt_d = rcnt_q + 4'd1;
        end
      end
      DONE: begin
        if (out_ready) begin
          if (in_valid) begin
            state_d = plaintext ^ rk_arr[0];
            rcnt_d  = 4'd1;
            fsm_d   = ROUND;
          end else begin
            fsm_d = IDLE;
          end
        end
      end
      default: begin
        rcnt_d = 4'd0;
        fsm_d  = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      rcnt_q  <= '0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
    end
  end

  assign out_valid  = (fsm_q == DONE);
  assign busy       = (fsm_q == ROUND);
  assign ciphertext = state_q;

endmodule

// File: tb/tb_aes_round_engine.sv
module tb_aes_round_engine;

  logic clk;
  logic rst_n;
  logic          in_valid  [3];
  logic          in_ready  [3];
  logic          out_valid [3];
  logic          out_ready [3];
  logic          busy      [3];
  logic [0:127]  pt        [3];
  logic [0:127]  ct        [3];
  logic [0:1919] rk_bus    [3];

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] sb [256];

  // Instance k uses KEY_LEN = 128 + 64*k.
  genvar gi;
  for (gi = 0; gi < 3; gi++) begin : g_dut
    localparam int RKW = 128 * (11 + 2*gi);
    aes_round_engine #(.KEY_LEN(128 + 64*gi)) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid[gi]),
      .in_ready   (in_ready[gi]),
      .plaintext  (pt[gi]),
      .round_keys (rk_bus[gi][0:RKW-1]),
      .out_valid  (out_valid[gi]),
      .out_ready  (out_ready[gi]),
      .ciphertext (ct[gi]),
      .busy       (busy[gi])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish, required finish before 1ms");
    $fatal(1, "timeout");
  end

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box from its definition: multiplicative inverse (x^254) then affine map.
  function automatic logic [7:0] sbox_def(input logic [7:0] x);
    logic [7:0] v;
    v = 8'h01;
    for (int i = 0; i < 254; i++) v = gmul(v, x);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction

  function automatic logic [0:1919] expand_key(input int klen, input logic [0:255] key);
    logic [0:1919] rk;
    logic [31:0]   w [60];
    logic [31:0]   t;
    logic [7:0]    rc;
    int nk, nw;
    nk = klen / 32;
    nw = 4 * (nk + 7);
    rk = '0;
    rc = 8'h01;
    for (int i = 0; i < nw; i++) begin
      if (i < nk) begin
        w[i] = key[32*i +: 32];
      end else begin
        t = w[i-1];
        if (i % nk == 0) begin
          t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
          rc = gmul(rc, 8'h02);
        end else if (nk > 6 && i % nk == 4) begin
          t = subw(t);
        end
        w[i] = w[i-nk] ^ t;
      end
      rk[32*i +: 32] = w[i];
    end
    return rk;
  endfunction

  function automatic logic [0:127] ref_encrypt(input int klen, input logic [0:1919] rk,
                                               input logic [0:127] p);
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [7:0] a0, a1, a2, a3;
    logic [0:127] res;
    int nr;
    nr = klen / 32 + 6;
    for (int i = 0; i < 16; i++) s[i] = p[8*i +: 8] ^ rk[8*i +: 8];
    for (int r = 1; r <= nr; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sb[s[i]];
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++)
          s[row + 4*c] = t[row + 4*((c + row) % 4)];
      if (r != nr) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[128*r + 8*i +: 8];
    end
    for (int i = 0; i < 16; i++) res[8*i +: 8] = s[i];
    return res;
  endfunction

  // ---------------- checking helpers ----------------
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  task automatic wait_valid(input int k, output int cyc);
    cyc = 0;
    while (!out_valid[k] && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic run_block(input int k, input logic [0:1919] rk, input logic [0:127] p,
                           input logic [0:127] exp, input string nm);
    int cyc;
    @(negedge clk);
    rk_bus[k] = rk; pt[k] = p; in_valid[k] = 1'b1; out_ready[k] = 1'b1;
    chk({nm, ".in_ready"}, 128'(in_ready[k]), 128'd1);
    @(posedge clk); #1;
    in_valid[k] = 1'b0;
    chk({nm, ".busy"}, 128'(busy[k]), 128'd1);
    wait_valid(k, cyc);
    chk({nm, ".latency"}, 128'(cyc), 128'(10 + 2*k));
    chk({nm, ".ct"}, ct[k], exp);
    @(posedge clk); #1;
    chk({nm, ".consumed"}, 128'(out_valid[k]), 128'd0);
    $display("txn %s: keylen=%0d pt=%h ct=%h latency=%0d", nm, 128 + 64*k, p, ct[k], cyc);
  endtask

  typedef struct {
    int           inst;
    logic [0:255] key;
    logic [0:127] p;
    logic [0:127] c;
  } kat_t;

  kat_t kats [4];

  initial begin
    logic [0:255]  key;
    logic [0:127]  p, p2, exp;
    logic [0:1919] rk;
    int cyc;
    bit saw;

    kats[0] = '{0, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0},
                128'h3243f6a8885a308d313198a2e0370734, 128'h3925841d02dc09fbdc118597196a0b32};
    kats[1] = '{0, {128'h000102030405060708090a0b0c0d0e0f, 128'h0},
                128'h00112233445566778899aabbccddeeff, 128'h69c4e0d86a7b0430d8cdb78070b4c55a};
    kats[2] = '{1, {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0},
                128'h00112233445566778899aabbccddeeff, 128'hdda97ca4864cdfe06eaf70a0ec0d7191};
    kats[3] = '{2, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
                128'h00112233445566778899aabbccddeeff, 128'h8ea2b7ca516745bfeafc49904b496089};

    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid[k] = 1'b0; out_ready[k] = 1'b0; pt[k] = '0; rk_bus[k] = '0;
    end
    for (int i = 0; i < 256; i++) sb[i] = sbox_def(8'(i));

    // Reset state
    #2;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("reset%0d.in_ready", k), 128'(in_ready[k]), 128'd1);
      chk($sformatf("reset%0d.out_valid", k), 128'(out_valid[k]), 128'd0);
      chk($sformatf("reset%0d.busy", k), 128'(busy[k]), 128'd0);
      chk($sformatf("reset%0d.ct", k), ct[k], 128'd0);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Known-answer vectors
    for (int v = 0; v < 4; v++) begin
      rk = expand_key(128 + 64*kats[v].inst, kats[v].key);
      run_block(kats[v].inst, rk, kats[v].p, kats[v].c, $sformatf("kat%0d", v));
    end

    // Random keys and blocks against the model
    for (int k = 0; k < 3; k++) begin
      for (int n = 0; n < 4; n++) begin
        for (int j = 0; j < 8; j++) key[32*j +: 32] = $urandom();
        for (int j = 0; j < 4; j++) p[32*j +: 32] = $urandom();
        rk  = expand_key(128 + 64*k, key);
        exp = ref_encrypt(128 + 64*k, rk, p);
        run_block(k, rk, p, exp, $sformatf("rnd%0d_%0d", k, n));
      end
    end

    // Back-pressure with an in_valid pulse during ROUND
    rk = expand_key(128, kats[0].key);
    @(negedge clk);
    rk_bus[0] = rk; pt[0] = kats[0].p; in_valid[0] = 1'b1; out_ready[0] = 1'b0;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    in_valid[0] = 1'b1; pt[0] = ~kats[0].p;
    #1;
    chk("pulse.in_ready", 128'(in_ready[0]), 128'd0);
    chk("pulse.busy", 128'(busy[0]), 128'd1);
    @(posedge clk); #1;
    in_valid[0] = 1'b0; pt[0] = kats[0].p;
    wait_valid(0, cyc);
    chk("bp.valid", 128'(out_valid[0]), 128'd1);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      chk($sformatf("bp.hold%0d.valid", i), 128'(out_valid[0]), 128'd1);
      chk($sformatf("bp.hold%0d.ct", i), ct[0], kats[0].c);
      chk($sformatf("bp.hold%0d.in_ready", i), 128'(in_ready[0]), 128'd0);
    end
    @(negedge clk);
    out_ready[0] = 1'b1;
    @(posedge clk); #1;
    chk("bp.release.valid", 128'(out_valid[0]), 128'd0);
    chk("bp.release.in_ready", 128'(in_ready[0]), 128'd1);
    saw = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      saw |= out_valid[0];
    end
    chk("bp.single_transfer", 128'(saw), 128'd0);
    $display("txn backpressure: ct=%h held 20 cycles", kats[0].c);

    // Back-to-back: second block accepted on the edge the first is consumed
    rk = expand_key(128, kats[1].key);
    for (int j = 0; j < 4; j++) p2[32*j +: 32] = $urandom();
    exp = ref_encrypt(128, rk, p2);
    @(negedge clk);
    rk_bus[0] = rk; pt[0] = kats[1].p; in_valid[0] = 1'b1; out_ready[0] = 1'b1;
    @(posedge clk); #1;
    pt[0] = p2;
    wait_valid(0, cyc);
    chk("b2b.first.latency", 128'(cyc), 128'd10);
    chk("b2b.first.ct", ct[0], kats[1].c);
    chk("b2b.handoff.in_ready", 128'(in_ready[0]), 128'd1);
    $display("txn b2b first: ct=%h latency=%0d", ct[0], cyc);
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    chk("b2b.handoff.busy", 128'(busy[0]), 128'd1);
    chk("b2b.handoff.valid", 128'(out_valid[0]), 128'd0);
    wait_valid(0, cyc);
    chk("b2b.second.spacing", 128'(cyc + 1), 128'd11);
    chk("b2b.second.ct", ct[0], exp);
    $display("txn b2b second: ct=%h spacing=%0d", ct[0], cyc + 1);
    @(posedge clk); #1;

    // Reset in the middle of the rounds
    rk = expand_key(128, kats[1].key);
    @(negedge clk);
    rk_bus[0] = rk; pt[0] = kats[1].p; in_valid[0] = 1'b1; out_ready[0] = 1'b1;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst.valid", 128'(out_valid[0]), 128'd0);
    chk("rst.busy", 128'(busy[0]), 128'd0);
    chk("rst.in_ready", 128'(in_ready[0]), 128'd1);
    @(negedge clk);
    rst_n = 1'b1;
    saw = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      saw |= out_valid[0];
    end
    chk("rst.no_valid", 128'(saw), 128'd0);
    $display("txn reset_abort: no result flagged");
    run_block(0, rk, kats[1].p, kats[1].c, "after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/aes_round_engine.md
Name: aes_round_engine

Overview:
- Iterative AES encryption core, one round per clock, directly downstream of key_schedule.
- Consumes key_schedule's flattened round-key bus (1408/1664/1920 bits for 128/192/256-bit keys) and a 128-bit plaintext block.
- Produces the 128-bit ciphertext.
- Uses valid/ready handshakes on both sides; reuses the existing sbox_128 for SubBytes.

Parameters:
KEY_LEN, 128, AES key length in bits; legal values 128/192/256 (anything else is an elaboration error).
NR, derived (10/12/14), number of rounds; localparam, not overridable.
RK_W, derived 128*(NR+1), width of the round-key bus.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous, active-low reset
in_valid  input  1  plaintext and round keys are presented
in_ready  output  1  engine can accept a block this cycle
plaintext  input  [0:127]  input block; bit 0 is the MSB of byte 0 (FIPS-197 order)
round_keys  input  [0:RK_W-1]  round key i occupies bits [128*i : 128*i+127]; identical layout to key_schedule output
out_valid  output  1  ciphertext is valid
out_ready  input  1  consumer accepts the ciphertext
ciphertext  output  [0:127]  result block
busy  output  1  high while FSM is in ROUND

Behaviour:
- FSM states: IDLE, ROUND, DONE. Registers: state_q[0:127], rcnt (4 bits), fsm.
- Reset (asynchronous, rst_n=0): fsm=IDLE, state_q=0, rcnt=0, out_valid=0, busy=0, ciphertext=0. in_ready=1 while in reset.
- in_ready is combinational: (fsm==IDLE) || (fsm==DONE && out_ready).
- Accept: in_valid && in_ready at a rising edge. Then state_q <= plaintext ^ round_keys[rk0], rcnt <= 1, fsm <= ROUND.
- ROUND, each edge: state_q <= aes_round(state_q, rk[rcnt], final = (rcnt==NR)).
  - final=1 skips MixColumns.
  - If rcnt==NR, fsm <= DONE; otherwise rcnt <= rcnt+1.
- Latency: out_valid rises NR cycles after the accept edge (10/12/14). Throughput: one block per NR+1 cycles without back-pressure.
- DONE: out_valid=1 and ciphertext=state_q, both held stable until out_ready.
  - out_valid && out_ready && !in_valid: fsm <= IDLE.
  - out_valid && out_ready && in_valid: back-to-back handoff. The result is consumed and the new block is accepted on the same edge (fsm <= ROUND). No bubble cycle.
- in_valid during ROUND is ignored (in_ready=0). The upstream must hold its data.
- round_keys are not latched. The system must hold round_keys stable from the accept edge until out_valid. Verification asserts this.
- rcnt never exceeds NR and is 0 in IDLE and DONE.
- rst_n asserted mid-ROUND or in DONE: the operation is aborted, out_valid drops immediately, and no partial result is ever flagged valid.
- out_valid is 0 in IDLE and ROUND. ciphertext outside DONE is don't-care but stays registered (no glitching).

Decomposition:
- Package aes_pkg:
  - function nr_of(key_len) returning 10/12/14
  - RK_W formula
  - FSM state encoding localparams (IDLE=2'd0, ROUND=2'd1, DONE=2'd2)
  - gf_xtime function for MixColumns
- Sub-module aes_round, purely combinational:
  - inputs: state[0:127], rk[0:127], final
  - output: next_state
  - function: SubBytes via existing sbox_128, then ShiftRows, then MixColumns (bypassed when final=1), then AddRoundKey
- aes_round_engine holds only the FSM, the counter, the key-slice mux and the registers.

Test Plan:
- KEY_LEN=128, key_schedule fed 2B7E151628AED2A6ABF7158809CF4F3C, plaintext 3243F6A8885A308D313198A2E0370734 -> out_valid exactly 10 cycles after accept, ciphertext 3925841D02DC09FBDC118597196A0B32.
- KEY_LEN=192, key 000102…1617, plaintext 00112233445566778899AABBCCDDEEFF -> ciphertext DDA97CA4864CDFE06EAF70A0EC0D7191 after 12 cycles. KEY_LEN=256, key 000102…1E1F -> 8EA2B7CA516745BFEAFC49904B496089 after 14 cycles.
- Back-pressure: hold out_ready=0 for 20 cycles in DONE -> out_valid and ciphertext stable, in_ready=0. Release -> single transfer, fsm returns to IDLE.
- Back-to-back: in_valid held high and out_ready tied 1 with two FIPS-197 C.1 blocks -> second accepted on the same edge the first is consumed. Results 69C4E0D86A7B0430D8CDB78070B4C55A at 11-cycle spacing.
- Reset mid-operation: assert rst_n=0 at round 5 for 1 cycle -> out_valid never rises, in_ready=1. A fresh block afterwards gives the correct ciphertext.
- in_valid pulsed during ROUND -> ignored, and the in-flight result is unchanged.
